// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   txq_state_t                  issue sequencer states (IDLE, ISSUE, WAIT)
//   UART_TXQ_DEPTH_LOG2_DEFAULT  default queue depth exponent (16 bytes)
//   DROP_MAX                     saturation value of the dropped-byte counter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } txq_state_t;

  localparam int         UART_TXQ_DEPTH_LOG2_DEFAULT = 4;
  localparam logic [7:0] DROP_MAX                    = 8'hFF;

endpackage

// File: rtl/uart_txq_ram.sv
// uart_txq_ram: byte storage for uart_tx_queue.
// Simple dual-port memory with a synchronous write and an asynchronous read.
// The combinational read lets the issue sequencer latch the head byte in the
// same cycle it decides to pop.
//   sys_clk  clock
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr    read address
//   rdata    read data (combinational from raddr)
module uart_txq_ram #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus issue sequencer in front of the uart
// transmitter. Producers push at full clock rate; bytes are handed to the uart
// one at a time with a one-cycle uart_tx_wr pulse, waiting for uart_tx_done
// before the next.
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   in_data, in_wr     producer byte and write strobe
//   full, empty, level registered occupancy status (one cycle behind pointers)
//   uart_tx_data/_wr   byte and strobe to the uart
//   uart_tx_done       completion pulse from the uart
//   overflow           sticky drop flag
//   drop_count         saturating dropped-byte counter
// Optional feature macro: UART_TXQ_OVF_EN enables overflow/drop_count;
// otherwise both are tied to zero and drops are silent.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_TXQ_DEPTH_LOG2_DEFAULT
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [7:0]          in_data,
  input  logic                in_wr,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic [7:0]          uart_tx_data,
  output logic                uart_tx_wr,
  input  logic                uart_tx_done,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam int              PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]   DEPTH = PW'(2**DEPTH_LOG2);

  logic [PW-1:0] wr_ptr, rd_ptr, occ;
  logic          full_now, has_data, push, pop;
  logic [7:0]    rd_data;
  txq_state_t    state;

  // Push gating and the sequencer use live pointer occupancy; the exported
  // flags are registered copies that trail by one cycle.
  assign occ      = wr_ptr - rd_ptr;
  assign full_now = (occ == DEPTH);
  assign has_data = (occ != '0);
  assign push     = in_wr && !full_now;
  assign pop      = (state == IDLE) && has_data;

  uart_txq_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .sys_clk (sys_clk),
    .we      (push),
    .waddr   (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata   (in_data),
    .raddr   (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata   (rd_data)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= occ;
      empty <= (occ == '0);
      full  <= full_now;
    end
  end

  // uart_tx_wr is registered: it is set on leaving ISSUE, so the pulse lands
  // in the first WAIT cycle, two edges after the pop. uart_tx_data is latched
  // at the pop and held until IDLE pops again.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      uart_tx_wr   <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      uart_tx_wr <= 1'b0;
      case (state)
        IDLE: if (has_data) begin
          uart_tx_data <= rd_data;
          state        <= ISSUE;
        end
        ISSUE: begin
          uart_tx_wr <= 1'b1;
          state      <= WAIT;
        end
        WAIT:    if (uart_tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_OVF_EN
  logic drop;
  assign drop = in_wr && full_now;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != DROP_MAX) drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign overflow   = 1'b0;
  assign drop_count = 8'h00;
`endif

endmodule
